ahb_param_default_slave: RTL and testbench

//  Parametrised AHB-Lite default slave, selected by the decoder for unmapped address space.

---
 rtl/ahb_param_default_slave.sv | 143 ++++++++++++++
 tb/tb_ahb_param_default_slave.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_param_default_slave.sv
// AHB-Lite default slave for unmapped address space: zero-wait OKAY for IDLE/BUSY,
// optional wait states then a two-cycle ERROR (or OKAY in RAZ/WI mode), plus fault capture.
module ahb_param_default_slave #(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       WAIT_STATES = 0,
  parameter bit                ERR_RESP    = 1'b1,
  parameter logic [DATA_W-1:0] RDATA_VAL   = '0,
  parameter int unsigned       CNT_W       = 16
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADYin,
  output logic [DATA_W-1:0] HRDATA,
  output logic [1:0]        HRESP,
  output logic              HREADYOUT,
  input  logic              err_clear,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              err_valid,
  output logic [ADDR_W-1:0] err_addr,
  output logic              err_write
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP1, ST_RESP2} state_t;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_STATES);

  state_t            state_q, state_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic              hreadyout_q, hreadyout_d;
  logic              hresp_err_q, hresp_err_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic              err_valid_q, err_valid_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic              err_write_q, err_write_d;
  logic              accept;
  logic              unused_inputs;

  assign unused_inputs = ^{HSIZE, HBURST, HWDATA, HTRANS[0]};

  // A new address phase is only taken while this slave's own data phase is ending.
  assign accept = HSEL & HREADYin & HTRANS[1] & hreadyout_q;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (WAIT_STATES != 0) begin
            state_d    = ST_WAIT;
            wait_cnt_d = WAIT_LD;
          end else begin
            state_d = ST_RESP1;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q <= 4'd1) state_d = ST_RESP1;
        else                    wait_cnt_d = wait_cnt_q - 4'd1;
      end
      ST_RESP1, ST_RESP2: begin
        // In OKAY mode RESP1 is already the final beat, so it behaves like RESP2.
        if (ERR_RESP && state_q == ST_RESP1) begin
          state_d = ST_RESP2;
        end else if (accept) begin
          if (WAIT_STATES != 0) begin
            state_d    = ST_WAIT;
            wait_cnt_d = WAIT_LD;
          end else begin
            state_d = ST_RESP1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    hreadyout_d = (state_d == ST_IDLE) || (state_d == ST_RESP2) ||
                  ((state_d == ST_RESP1) && !ERR_RESP);
    hresp_err_d = ERR_RESP && ((state_d == ST_RESP1) || (state_d == ST_RESP2));
  end

  always_comb begin
    err_cnt_d   = err_cnt_q;
    err_valid_d = err_valid_q;
    err_addr_d  = err_addr_q;
    err_write_d = err_write_q;
    if (err_clear) begin
      err_cnt_d   = '0;
      err_valid_d = 1'b0;
      err_addr_d  = '0;
      err_write_d = 1'b0;
    end
    if (accept) begin
      if (err_cnt_d != '1) err_cnt_d = err_cnt_d + CNT_W'(1);
      if (!err_valid_d) begin
        err_valid_d = 1'b1;
        err_addr_d  = HADDR;
        err_write_d = HWRITE;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= '0;
      hreadyout_q <= 1'b1;
      hresp_err_q <= 1'b0;
      err_cnt_q   <= '0;
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
      err_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      hreadyout_q <= hreadyout_d;
      hresp_err_q <= hresp_err_d;
      err_cnt_q   <= err_cnt_d;
      err_valid_q <= err_valid_d;
      err_addr_q  <= err_addr_d;
      err_write_q <= err_write_d;
    end
  end

  assign HRDATA    = RDATA_VAL;
  assign HRESP     = {1'b0, hresp_err_q};
  assign HREADYOUT = hreadyout_q;
  assign err_cnt   = err_cnt_q;
  assign err_valid = err_valid_q;
  assign err_addr  = err_addr_q;
  assign err_write = err_write_q;

endmodule

// File: tb/tb_ahb_param_default_slave.sv
// Bench for ahb_param_default_slave: four parameterisations share one bus stimulus;
// a vector table checks the default build, a response-beat scoreboard checks all four.
module tb_ahb_param_default_slave;
  localparam int N = 4;

  typedef struct packed {logic rdy; logic [1:0] resp;} beat_t;
  localparam beat_t B_WAIT = 3'b000;
  localparam beat_t B_ERR0 = 3'b001;
  localparam beat_t B_ERR1 = 3'b101;
  localparam beat_t B_OK   = 3'b100;

  localparam int unsigned M_WS   [N] = '{0, 2, 0, 0};
  localparam bit          M_ERR  [N] = '{1'b1, 1'b1, 1'b1, 1'b0};
  localparam logic [15:0] M_CMAX [N] = '{16'hFFFF, 16'hFFFF, 16'h0003, 16'hFFFF};
  localparam logic [31:0] M_RD   [N] = '{32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF};

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE, HBURST;
  logic [31:0] HWDATA;
  logic        hready_ext;
  logic        err_clear;

  logic [31:0] hrdata [N];
  logic [1:0]  hresp  [N];
  logic        hrdy   [N];
  logic [15:0] cnt    [N];
  logic [1:0]  cnt2;
  logic        vld    [N];
  logic [31:0] eaddr  [N];
  logic        ewr    [N];

  assign cnt[2] = {14'd0, cnt2};

  always #5 HCLK = ~HCLK;

  ahb_param_default_slave #(.WAIT_STATES(0)) u0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
    .HREADYin(hrdy[0] & hready_ext), .HRDATA(hrdata[0]), .HRESP(hresp[0]),
    .HREADYOUT(hrdy[0]), .err_clear(err_clear), .err_cnt(cnt[0]), .err_valid(vld[0]),
    .err_addr(eaddr[0]), .err_write(ewr[0]));

  ahb_param_default_slave #(.WAIT_STATES(2)) u1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
    .HREADYin(hrdy[1] & hready_ext), .HRDATA(hrdata[1]), .HRESP(hresp[1]),
    .HREADYOUT(hrdy[1]), .err_clear(err_clear), .err_cnt(cnt[1]), .err_valid(vld[1]),
    .err_addr(eaddr[1]), .err_write(ewr[1]));

  ahb_param_default_slave #(.CNT_W(2)) u2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
    .HREADYin(hrdy[2] & hready_ext), .HRDATA(hrdata[2]), .HRESP(hresp[2]),
    .HREADYOUT(hrdy[2]), .err_clear(err_clear), .err_cnt(cnt2), .err_valid(vld[2]),
    .err_addr(eaddr[2]), .err_write(ewr[2]));

  ahb_param_default_slave #(.ERR_RESP(1'b0), .RDATA_VAL(32'hDEAD_BEEF)) u3 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
    .HREADYin(hrdy[3] & hready_ext), .HRDATA(hrdata[3]), .HRESP(hresp[3]),
    .HREADYOUT(hrdy[3]), .err_clear(err_clear), .err_cnt(cnt[3]), .err_valid(vld[3]),
    .err_addr(eaddr[3]), .err_write(ewr[3]));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: the beat each slave should be showing now, plus queued future beats.
  beat_t       m_cur   [N];
  beat_t       sbq     [N][$];
  logic [15:0] m_cnt   [N];
  logic        m_valid [N];
  logic [31:0] m_addr  [N];
  logic        m_write [N];

  typedef struct {
    logic        hsel;
    logic [1:0]  htrans;
    logic [31:0] addr;
    logic        wr;
    logic        clr;
    logic        rext;
    logic        e_rdy;
    logic [1:0]  e_resp;
    logic [15:0] e_cnt;
    logic        e_vld;
    logic [31:0] e_addr;
    logic        e_wr;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic hsel, input logic [1:0] tr, input logic [31:0] a,
                       input logic w, input logic c, input logic re);
    HSEL = hsel; HTRANS = tr; HADDR = a; HWRITE = w; err_clear = c; hready_ext = re;
    HWDATA = $urandom; HSIZE = 3'($urandom_range(0, 7)); HBURST = 3'($urandom_range(0, 7));
  endtask

  task automatic drive_idle();
    drive(1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      sbq[i].delete();
      m_cur[i] = B_OK; m_cnt[i] = '0; m_valid[i] = 1'b0; m_addr[i] = '0; m_write[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < N; i++) begin
      logic acc;
      acc = HSEL && HTRANS[1] && hready_ext && m_cur[i].rdy;
      if (err_clear) begin
        m_cnt[i] = '0; m_valid[i] = 1'b0; m_addr[i] = '0; m_write[i] = 1'b0;
      end
      if (acc) begin
        if (m_cnt[i] != M_CMAX[i]) m_cnt[i] = m_cnt[i] + 16'd1;
        if (!m_valid[i]) begin
          m_valid[i] = 1'b1; m_addr[i] = HADDR; m_write[i] = HWRITE;
        end
        for (int w = 0; w < int'(M_WS[i]); w++) sbq[i].push_back(B_WAIT);
        if (M_ERR[i]) begin
          sbq[i].push_back(B_ERR0);
          sbq[i].push_back(B_ERR1);
        end else begin
          sbq[i].push_back(B_OK);
        end
      end
      m_cur[i] = (sbq[i].size() > 0) ? sbq[i].pop_front() : B_OK;
    end
  endtask

  task automatic check_sb();
    for (int i = 0; i < N; i++) begin
      check($sformatf("rdy%0d", i),   {31'd0, hrdy[i]}, {31'd0, m_cur[i].rdy});
      check($sformatf("resp%0d", i),  {30'd0, hresp[i]}, {30'd0, m_cur[i].resp});
      check($sformatf("cnt%0d", i),   {16'd0, cnt[i]}, {16'd0, m_cnt[i]});
      check($sformatf("valid%0d", i), {31'd0, vld[i]}, {31'd0, m_valid[i]});
      check($sformatf("addr%0d", i),  eaddr[i], m_addr[i]);
      check($sformatf("write%0d", i), {31'd0, ewr[i]}, {31'd0, m_write[i]});
      check($sformatf("rdata%0d", i), hrdata[i], M_RD[i]);
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge HCLK);
    #1;
    check_sb();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // hsel htrans addr wr clr rext | rdy resp cnt vld addr wr   (outputs after the edge)
    vecs[0]  = '{1'b1, 2'b00, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 16'd0, 1'b0, 32'h0,         1'b0};
    vecs[1]  = '{1'b1, 2'b01, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 16'd0, 1'b0, 32'h0,         1'b0};
    vecs[2]  = '{1'b0, 2'b10, 32'h0000_000A, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 16'd0, 1'b0, 32'h0,         1'b0};
    vecs[3]  = '{1'b1, 2'b10, 32'h0000_000B, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 16'd0, 1'b0, 32'h0,         1'b0};
    vecs[4]  = '{1'b1, 2'b10, 32'hF000_0010, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 16'd1, 1'b1, 32'hF000_0010, 1'b0};
    vecs[5]  = '{1'b0, 2'b00, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 16'd1, 1'b1, 32'hF000_0010, 1'b0};
    vecs[6]  = '{1'b0, 2'b00, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 16'd1, 1'b1, 32'hF000_0010, 1'b0};
    vecs[7]  = '{1'b1, 2'b10, 32'h0000_0100, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 16'd2, 1'b1, 32'hF000_0010, 1'b0};
    vecs[8]  = '{1'b1, 2'b10, 32'h0000_0200, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 16'd2, 1'b1, 32'hF000_0010, 1'b0};
    vecs[9]  = '{1'b1, 2'b10, 32'h0000_0200, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 16'd3, 1'b1, 32'hF000_0010, 1'b0};
    vecs[10] = '{1'b0, 2'b00, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 16'd3, 1'b1, 32'hF000_0010, 1'b0};
    vecs[11] = '{1'b0, 2'b00, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 16'd3, 1'b1, 32'hF000_0010, 1'b0};
    vecs[12] = '{1'b0, 2'b00, 32'h0,         1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 16'd0, 1'b0, 32'h0,         1'b0};
    vecs[13] = '{1'b1, 2'b10, 32'h0000_0300, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 16'd1, 1'b1, 32'h0000_0300, 1'b1};
    vecs[14] = '{1'b0, 2'b00, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 16'd1, 1'b1, 32'h0000_0300, 1'b1};
    vecs[15] = '{1'b0, 2'b00, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 16'd1, 1'b1, 32'h0000_0300, 1'b1};
    vecs[16] = '{1'b0, 2'b00, 32'h0,         1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 16'd0, 1'b0, 32'h0,         1'b0};

    HRESETn = 1'b0;
    drive_idle();
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    for (int i = 0; i < N; i++) begin
      check($sformatf("rst_rdy%0d", i),  {31'd0, hrdy[i]}, 32'd1);
      check($sformatf("rst_resp%0d", i), {30'd0, hresp[i]}, 32'd0);
      check($sformatf("rst_cnt%0d", i),  {16'd0, cnt[i]}, 32'd0);
      check($sformatf("rst_vld%0d", i),  {31'd0, vld[i]}, 32'd0);
      check($sformatf("rst_addr%0d", i), eaddr[i], 32'd0);
    end
    HRESETn = 1'b1;
    model_reset();

    for (int v = 0; v < 17; v++) begin
      drive(vecs[v].hsel, vecs[v].htrans, vecs[v].addr, vecs[v].wr, vecs[v].clr, vecs[v].rext);
      cycle();
      check($sformatf("vec%0d_rdy", v),   {31'd0, hrdy[0]}, {31'd0, vecs[v].e_rdy});
      check($sformatf("vec%0d_resp", v),  {30'd0, hresp[0]}, {30'd0, vecs[v].e_resp});
      check($sformatf("vec%0d_cnt", v),   {16'd0, cnt[0]}, {16'd0, vecs[v].e_cnt});
      check($sformatf("vec%0d_vld", v),   {31'd0, vld[0]}, {31'd0, vecs[v].e_vld});
      check($sformatf("vec%0d_addr", v),  eaddr[0], vecs[v].e_addr);
      check($sformatf("vec%0d_write", v), {31'd0, ewr[0]}, {31'd0, vecs[v].e_wr});
    end
    drive_idle();
    repeat (4) cycle();

    // Held NONSEQ: the default build takes one every two cycles, the 2-bit counter saturates.
    drive(1'b1, 2'b10, 32'h0000_0400, 1'b0, 1'b0, 1'b1);
    repeat (10) cycle();
    drive_idle();
    repeat (6) cycle();
    check("sat_cnt", {16'd0, cnt[2]}, 32'd3);
    check("five_cnt", {16'd0, cnt[0]}, 32'd5);
    check("first_addr", eaddr[0], 32'h0000_0400);

    // RAZ/WI build: single-cycle OKAY carrying the constant read data.
    drive(1'b1, 2'b10, 32'h0000_0600, 1'b0, 1'b0, 1'b1);
    cycle();
    check("raz_rdy", {31'd0, hrdy[3]}, 32'd1);
    check("raz_resp", {30'd0, hresp[3]}, 32'd0);
    check("raz_rdata", hrdata[3], 32'hDEAD_BEEF);
    drive_idle();
    repeat (4) cycle();

    // Asynchronous reset in RESP1 aborts the error response immediately.
    drive(1'b1, 2'b10, 32'h0000_0500, 1'b0, 1'b0, 1'b1);
    cycle();
    check("pre_rst_rdy", {31'd0, hrdy[0]}, 32'd0);
    check("pre_rst_resp", {30'd0, hresp[0]}, 32'd1);
    drive_idle();
    #2;
    HRESETn = 1'b0;
    #1;
    check("arst_rdy", {31'd0, hrdy[0]}, 32'd1);
    check("arst_resp", {30'd0, hresp[0]}, 32'd0);
    check("arst_vld", {31'd0, vld[0]}, 32'd0);
    check("arst_cnt", {16'd0, cnt[0]}, 32'd0);
    model_reset();
    @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (3) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
